div_datapath: RTL and testbench

- Datapath for the restoring integer divider. It is driven cycle by cycle by the divider control unit's strobes and returns the status flags r_lt_y and count_equ_0 to that unit.
- Holds four storage elements: dividend/quotient shift register X, divisor register Y, partial-remainder register R (WIDTH+1 bits), and the iteration counter.
- Produces quotient, remainder, and a muxed result for display.

---
 rtl/div_datapath.sv | 117 +++++++++++
 tb/tb_div_datapath.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/div_datapath.sv
// Restoring-divider datapath: X/Y/R registers, iteration counter, status flags; DIV_BY_ZERO_EN adds the dbz trap.
// Latency: strobes take effect on the next clk edge; r_lt_y/count_equ_0 are combinational from the registers.
// Backpressure: none, the control unit strobes this block every cycle.
module div_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             ld,
    input  logic             ud,
    input  logic             ce,
    input  logic             ldx,
    input  logic             slx,
    input  logic             srx,
    input  logic             cex,
    input  logic             ldr,
    input  logic             slr,
    input  logic             srr,
    input  logic             cer,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    output logic             r_lt_y,
    output logic             count_equ_0,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
`ifdef DIV_BY_ZERO_EN
    output logic             dbz,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rn;
    logic             qbit;
    logic             blk;

`ifdef DIV_BY_ZERO_EN
    logic dbz_q, dbz_d;

    always_comb begin
        dbz_d = dbz_q;
        if (ldx) dbz_d = (divisor == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) dbz_q <= 1'b0;
        else     dbz_q <= dbz_d;
    end

    assign blk = dbz_q;
    assign dbz = dbz_q;
`else
    assign blk = 1'b0;
`endif

    assign r_lt_y      = r_q < {1'b0, y_q};
    assign count_equ_0 = (cnt_q == '0);
    assign rn          = r_lt_y ? r_q : r_q - {1'b0, y_q};
    // A trapped divide freezes R on restoring steps and feeds zero quotient bits.
    assign qbit        = s1 & ~r_lt_y & ~blk;

    always_comb begin
        x_d = x_q;
        if (cex)      x_d = '0;
        else if (ldx) x_d = dividend;
        else if (slx) x_d = {x_q[WIDTH-2:0], qbit};
        else if (srx) x_d = {1'b0, x_q[WIDTH-1:1]};
    end

    always_comb begin
        y_d = y_q;
        if (ldx) y_d = divisor;
    end

    always_comb begin
        r_d = r_q;
        if (cer)                 r_d = '0;
        else if (ldr)            r_d = s2 ? (blk ? r_q : rn) : '0;
        else if (slr && !s1)     r_d = {r_q[WIDTH-1:0], x_q[WIDTH-1]};
        else if (slr)            r_d = blk ? r_q : {rn[WIDTH-1:0], x_q[WIDTH-1]};
        else if (srr)            r_d = {1'b0, r_q[WIDTH:1]};
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ld)      cnt_d = CNT_INIT;
        else if (ce) cnt_d = ud ? cnt_q + CW'(1) : cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            r_q   <= r_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient  = x_q;
    assign remainder = r_q[WIDTH-1:0];
    assign result    = s3 ? remainder : quotient;

endmodule

// File: tb/tb_div_datapath.sv
// Directed bench for div_datapath: strobe sequences with hand-computed expectations plus a divisor sweep.
module tb_div_datapath;

    logic       clk, rst;
    logic [3:0] dividend, divisor;
    logic       ld, ud, ce, ldx, slx, srx, cex, ldr, slr, srr, cer, s1, s2, s3;
    logic       r_lt_y, count_equ_0;
    logic [3:0] quotient, remainder, result;
`ifdef DIV_BY_ZERO_EN
    logic       dbz;
`endif

    int chk_cnt = 0;
    int err_cnt = 0;
    int r_exp [4] = '{3, 6, 5, 2};
    int x_exp [4] = '{4, 8, 1, 3};

    div_datapath #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor),
        .ld(ld), .ud(ud), .ce(ce), .ldx(ldx), .slx(slx), .srx(srx), .cex(cex),
        .ldr(ldr), .slr(slr), .srr(srr), .cer(cer), .s1(s1), .s2(s2), .s3(s3),
        .r_lt_y(r_lt_y), .count_equ_0(count_equ_0),
        .quotient(quotient), .remainder(remainder),
`ifdef DIV_BY_ZERO_EN
        .dbz(dbz),
`endif
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ld = 0; ud = 0; ce = 0; ldx = 0; slx = 0; srx = 0; cex = 0;
        ldr = 0; slr = 0; srr = 0; cer = 0; s1 = 0; s2 = 0;
    endtask

    task automatic load_ops(input logic [3:0] a, input logic [3:0] b);
        ld = 1; ldx = 1; ldr = 1; s2 = 0; dividend = a; divisor = b;
        tick; idle;
    endtask

    task automatic div_step(input logic sel);
        slx = 1; slr = 1; s1 = sel;
        tick; idle;
    endtask

    task automatic count_step(input logic up);
        ce = 1; ud = up;
        tick; idle;
    endtask

    task automatic run_div(input logic [3:0] a, input logic [3:0] b);
        load_ops(a, b);
        div_step(1'b0);
        repeat (4) div_step(1'b1);
        srr = 1; tick; idle;
    endtask

    initial begin
        idle; s3 = 0; dividend = '0; divisor = '0;
        rst = 1;
        repeat (2) tick;
        check("rst_q", 32'(quotient), 0);
        check("rst_r", 32'(remainder), 0);
        check("rst_res", 32'(result), 0);
        check("rst_ceq", 32'(count_equ_0), 1);
        check("rst_rlty", 32'(r_lt_y), 0);
`ifdef DIV_BY_ZERO_EN
        check("rst_dbz", 32'(dbz), 0);
`endif
        rst = 0;

        // 13 / 4 with per-step checks and counter countdown
        load_ops(4'd13, 4'd4);
        check("ld_x", 32'(quotient), 13);
        check("ld_r", 32'(remainder), 0);
        check("ld_ceq", 32'(count_equ_0), 0);
        check("ld_rlty", 32'(r_lt_y), 1);
        repeat (3) count_step(1'b0);
        check("cnt3_ceq", 32'(count_equ_0), 0);
        count_step(1'b0);
        check("cnt4_ceq", 32'(count_equ_0), 1);
        div_step(1'b0);
        check("s0_r", 32'(remainder), 1);
        check("s0_x", 32'(quotient), 10);
        for (int i = 0; i < 4; i++) begin
            div_step(1'b1);
            check("s1_r", 32'(remainder), 32'(r_exp[i]));
            check("s1_x", 32'(quotient), 32'(x_exp[i]));
        end
        srr = 1; tick; idle;
        check("q13_4", 32'(quotient), 3);
        check("r13_4", 32'(remainder), 1);
        s3 = 0; #1;
        check("res_q", 32'(result), 3);
        s3 = 1; #1;
        check("res_r", 32'(result), 1);
        s3 = 0;

        // Priorities: R=1, Y=4, X=3 here
        cer = 1; ldr = 1; s2 = 1; slr = 1; tick; idle;
        check("pri_r", 32'(remainder), 0);
        cex = 1; ldx = 1; slx = 1; dividend = 4'd9; divisor = 4'd0; tick; idle;
        check("pri_x", 32'(quotient), 0);
        check("pri_y", 32'(r_lt_y), 0);

        load_ops(4'd13, 4'd4);
        srx = 1; tick; idle;
        check("srx", 32'(quotient), 6);

        // Plain R shifts then a restoring load
        load_ops(4'd15, 4'd2);
        slr = 1; tick; idle;
        slr = 1; tick; idle;
        check("slr0_r", 32'(remainder), 3);
        check("slr0_rlty", 32'(r_lt_y), 0);
        ldr = 1; s2 = 1; tick; idle;
        check("ldr_rn", 32'(remainder), 1);
        check("ldr_rlty", 32'(r_lt_y), 1);

        // Counter priority and wrap
        ld = 1; ce = 1; ud = 1; tick; idle;
        check("ldce_ceq", 32'(count_equ_0), 0);
        repeat (3) count_step(1'b0);
        check("ldce3", 32'(count_equ_0), 0);
        count_step(1'b0);
        check("ldce4", 32'(count_equ_0), 1);
        count_step(1'b0);
        check("wrap_dn", 32'(count_equ_0), 0);
        count_step(1'b1);
        check("wrap_up", 32'(count_equ_0), 1);

        run_div(4'd15, 4'd1);
        check("q15_1", 32'(quotient), 15);
        check("r15_1", 32'(remainder), 0);
        run_div(4'd7, 4'd9);
        check("q7_9", 32'(quotient), 0);
        check("r7_9", 32'(remainder), 7);
        run_div(4'd15, 4'd15);
        check("q15_15", 32'(quotient), 1);
        check("r15_15", 32'(remainder), 0);

        // Reset mid-division overrides concurrent strobes
        load_ops(4'd13, 4'd4);
        div_step(1'b0);
        div_step(1'b1);
        div_step(1'b1);
        check("mid_r", 32'(remainder), 6);
        rst = 1; slx = 1; slr = 1; s1 = 1; ld = 1; ldx = 1; ldr = 1; s2 = 1;
        tick; idle; rst = 0;
        check("mrst_q", 32'(quotient), 0);
        check("mrst_r", 32'(remainder), 0);
        check("mrst_ceq", 32'(count_equ_0), 1);
        check("mrst_rlty", 32'(r_lt_y), 0);
        run_div(4'd9, 4'd2);
        check("q9_2", 32'(quotient), 4);
        check("r9_2", 32'(remainder), 1);

        run_div(4'd9, 4'd0);
`ifdef DIV_BY_ZERO_EN
        check("dbz_flag", 32'(dbz), 1);
        check("q9_0", 32'(quotient), 0);
        check("r9_0", 32'(remainder), 0);
`else
        check("q9_0", 32'(quotient), 15);
        check("r9_0", 32'(remainder), 9);
`endif

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(4'(a), 4'(b));
                check("sweep_q", 32'(quotient), 32'(a / b));
                check("sweep_r", 32'(remainder), 32'(a % b));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
